// File: rtl/usbh_rx_data_checker.sv
// USB host receive checker: validates PID, forwards payload with the two CRC
// bytes stripped, and checks the data CRC16 residual at end of packet.

module usbh_crc16 (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] c;

  always_comb begin
    c = crc_i ^ {8'h00, data_i};
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 16'hA001;
      else      c = c >> 1;
    end
    crc_o = c;
  end
endmodule

module usbh_rx_data_checker #(
  parameter int MAX_BYTES = 1023
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_active_i,
  input  logic                           rx_valid_i,
  input  logic [7:0]                     rx_data_i,
  output logic                           data_valid_o,
  output logic [7:0]                     data_o,
  output logic                           done_o,
  output logic [7:0]                     pid_o,
  output logic                           pid_err_o,
  output logic                           crc_err_o,
  output logic                           len_err_o,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count_o
);
  localparam int CW = $clog2(MAX_BYTES+1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, PID, DATA, HSHK, DISCARD} state_e;

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic          silent_q, silent_d;
  logic [7:0]    pid_q, pid_d;
  logic          pid_err_q, pid_err_d;
  logic          crc_err_q, crc_err_d;
  logic          len_err_q, len_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    buf0_q, buf0_d;
  logic [7:0]    buf1_q, buf1_d;
  logic [1:0]    bufn_q, bufn_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          done_q, done_d;

  logic [15:0]   crc_nxt;
  logic          is_data, is_hshk;

  usbh_crc16 u_crc16 (
    .crc_i  (crc_q),
    .data_i (rx_data_i),
    .crc_o  (crc_nxt)
  );

  assign is_data = rx_data_i inside {8'hC3, 8'h4B, 8'h87, 8'h0F};
  assign is_hshk = rx_data_i inside {8'hD2, 8'h5A, 8'h1E, 8'h96};

  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    silent_d  = silent_q;
    pid_d     = pid_q;
    pid_err_d = pid_err_q;
    crc_err_d = crc_err_q;
    len_err_d = len_err_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    bufn_d    = bufn_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_active_i) begin
          // First cycle out of reset with the line active: the packet was
          // already in flight, so drop it without reporting.
          if (armed_q) begin
            state_d   = PID;
            pid_err_d = 1'b0;
            crc_err_d = 1'b0;
            len_err_d = 1'b0;
            cnt_d     = '0;
            crc_d     = '1;
            bufn_d    = '0;
          end else begin
            state_d  = DISCARD;
            silent_d = 1'b1;
          end
        end
      end

      PID: begin
        if (rx_valid_i) begin
          pid_d     = rx_data_i;
          pid_err_d = (rx_data_i[3:0] != ~rx_data_i[7:4]);
          if (is_data)      state_d = DATA;
          else if (is_hshk) state_d = HSHK;
          else begin
            pid_err_d = 1'b1;
            state_d   = DISCARD;
          end
        end
        if (!rx_active_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!rx_valid_i)  pid_err_d = 1'b1;
          else if (is_data) crc_err_d = 1'b1;
        end
      end

      DATA: begin
        if (rx_valid_i) begin
          crc_d = crc_nxt;
          unique case (bufn_q)
            2'd0: begin
              buf0_d = rx_data_i;
              bufn_d = 2'd1;
            end
            2'd1: begin
              buf1_d = rx_data_i;
              bufn_d = 2'd2;
            end
            default: begin
              if (cnt_q == MaxCnt) begin
                len_err_d = 1'b1;
              end else begin
                dv_d   = 1'b1;
                dout_d = buf0_q;
                cnt_d  = cnt_q + CW'(1);
              end
              buf0_d = buf1_q;
              buf1_d = rx_data_i;
            end
          endcase
        end
        // The two held bytes at end of packet are the CRC field.
        if (!rx_active_i) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          crc_err_d = (bufn_d != 2'd2) || (crc_d != 16'hB001);
        end
      end

      HSHK: begin
        if (rx_valid_i) len_err_d = 1'b1;
        if (!rx_active_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      DISCARD: begin
        if (!rx_active_i) begin
          state_d  = IDLE;
          done_d   = !silent_q;
          silent_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      silent_q  <= 1'b0;
      pid_q     <= '0;
      pid_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
      crc_q     <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      bufn_q    <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      silent_q  <= silent_d;
      pid_q     <= pid_d;
      pid_err_q <= pid_err_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      bufn_q    <= bufn_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      done_q    <= done_d;
    end
  end

  assign data_valid_o = dv_q;
  assign data_o       = dout_q;
  assign done_o       = done_q;
  assign pid_o        = pid_q;
  assign pid_err_o    = pid_err_q;
  assign crc_err_o    = crc_err_q;
  assign len_err_o    = len_err_q;
  assign byte_count_o = cnt_q;

endmodule

// File: doc/usbh_rx_data_checker.md
# usbh_rx_data_checker

Receive-side packet checker for the USB host controller: sits between the UTMI-style receive byte stream and the host SIE. Captures and validates the PID, forwards payload bytes while stripping the trailing two CRC bytes, and runs the 16-bit data CRC through a `usbh_crc16` instance. At end of packet it reports PID, payload length and error flags. It is the checking counterpart of the transmit-side CRC16 generation.

## Interface
- `MAX_BYTES`, default 1023: maximum payload bytes, excluding PID and CRC.
- `clk_i` input 1: single clock; all logic rising-edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `rx_active_i` input 1: high for the duration of a received packet.
- `rx_valid_i` input 1: `rx_data_i` holds a byte this cycle. Sampled only while `rx_active_i` is high, or in the cycle it falls.
- `rx_data_i` input 8: received byte, same byte convention as the transmit path.
- `data_valid_o` output 1: `data_o` holds one payload byte.
- `data_o` output 8: payload byte.
- `done_o` output 1: one-cycle end-of-packet pulse.
- `pid_o` output 8: captured PID byte.
- `pid_err_o` output 1: PID check failed.
- `crc_err_o` output 1: CRC residual wrong, or packet too short.
- `len_err_o` output 1: payload exceeded `MAX_BYTES`, or bytes followed a handshake PID.
- `byte_count_o` output `$clog2(MAX_BYTES+1)`: payload bytes forwarded.

## Operation
- States: `IDLE`, `PID`, `DATA`, `HSHK`, `DISCARD`.
- **IDLE**
  - On `rx_active_i`=1: go to `PID`.
  - Entering `PID` clears `pid_err_o`, `crc_err_o`, `len_err_o` and `byte_count_o`, loads the CRC register with 16'hFFFF, and empties the 2-byte holding buffer.
- **PID** (first valid byte)
  - Latch the byte into `pid_o`.
  - `pid_err_o` = (`pid[3:0]` != ~`pid[7:4]`).
  - Data PIDs 0xC3, 0x4B, 0x87, 0x0F go to `DATA`.
  - Handshake PIDs 0xD2, 0x5A, 0x1E, 0x96 go to `HSHK`.
  - Any other PID sets `pid_err_o` and goes to `DISCARD`.
- **DATA** (each valid byte)
  - CRC register <= `crc16(crc, byte)`.
  - The byte is shifted into the 2-entry holding buffer.
  - If the buffer was already full, the oldest byte is emitted on `data_o` and `byte_count_o` increments.
  - If `byte_count_o` = `MAX_BYTES`, set `len_err_o` and suppress further emission; CRC continues.
- **HSHK**: any further valid byte sets `len_err_o`.
- **DISCARD**: ignore bytes; wait for `rx_active_i`=0.
- **End of packet** (`rx_active_i` falls in `PID`, `DATA` or `HSHK`)
  - Finish processing a byte valid in the same cycle.
  - Pulse `done_o`, return to `IDLE`.
  - Buffered bytes are the CRC and are never emitted.
  - In `DATA`: `crc_err_o` = (fewer than 2 bytes after PID) OR (final CRC register != 16'hB001).
  - Packet ending in `PID` with no byte: `pid_err_o`=1.
- **End of packet from `DISCARD`**: pulse `done_o`, with `pid_err_o` held.
- Status outputs (`pid_o`, flags, count) hold from `done_o` until the next packet start.
- **Reset mid-packet**
  - All state cleared.
  - If `rx_active_i` is high at reset release, enter `DISCARD`. No `done_o` for that packet; status stays at reset values.

## Timing
- Reset values: `data_valid_o`=0, `data_o`=0, `done_o`=0, `pid_o`=0, all error flags 0, `byte_count_o`=0, state `IDLE`.
- All outputs are registered.
- Payload latency: `data_valid_o` asserts the cycle after the `rx_valid_i` that pushes the byte out of the buffer, i.e. payload byte N appears one cycle after input byte N+2 (PID excluded).
- `done_o` and final flags are valid in the cycle after `rx_active_i` is sampled low.
- At most one `data_valid_o` per cycle; no backpressure.
- `rx_active_i` rising in the cycle after `done_o` is accepted, giving back-to-back packets.

## Test plan
- **DATA0 zero-length**: PID 0xC3, CRC bytes 0x00 0x00 -> `done_o`, `pid_o`=0xC3, `byte_count_o`=0, `crc_err_o`=0, no `data_valid_o`.
- **DATA1 payload**: PID 0x4B, payload 0x01 0x02 0x03 + correct CRC -> 3 `data_valid_o` pulses with 0x01, 0x02, 0x03, each one cycle after input bytes 3, 4, 5; `byte_count_o`=3, no errors. Flip one payload bit -> same bytes forwarded, `crc_err_o`=1.
- **Bad PIDs**:
  - PID 0xC2 -> `pid_err_o`=1, `done_o` on `rx_active_i` fall, no data output.
  - PID 0xA5 (SOF) -> `pid_err_o`=1, bytes discarded.
- **Handshake**:
  - ACK 0xD2 alone -> `done_o`, no errors.
  - ACK followed by 0x00 -> `len_err_o`=1.
- **Length and short packets**:
  - `MAX_BYTES`=4 with 6 payload bytes -> exactly 4 emitted, `len_err_o`=1.
  - DATA0 + one byte -> `crc_err_o`=1.
- **Reset**:
  - Assert `rst_ni` mid-DATA with `rx_active_i` held high -> outputs at reset values, rest of packet ignored, no `done_o`; next packet decodes normally.
  - Back-to-back packets with one idle cycle -> both reported correctly.
